// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core.
//
// Captures the decode-stage operands, register addresses and control bits,
// then applies the EX-stage forwarding muxes (MEM / WB) and the ALUSrc
// immediate mux so the ALU sees ready-to-use SrcA / SrcB operands.
//
// Ports:
//   CLK, RST                 clock (rising edge), async active-low reset
//   StallE, FlushE           hold / bubble controls from the hazard unit
//   RD1D, RD2D, SignImmD     decode-stage operands and immediate
//   RsD, RtD, RdD            decode-stage register addresses
//   ALUControlD, *D controls decode-stage control bits
//   ForwardAE, ForwardBE     forward selects (00 reg, 01 WB, 10 MEM, 11 reg)
//   ALUOutM, ResultW         forwarding sources from MEM and WB
//   SrcAE, SrcBE             ALU operands
//   ALUControlE              ALU op code (passed through)
//   WriteDataE               store data (forwarded rt, never the immediate)
//   WriteRegE                destination register (RegDst mux)
//   RsE, RtE                 source addresses for the hazard unit
//   RegWriteE, MemWriteE, MemtoRegE  control to later stages
//   ValidE                   E holds a real instruction

module id_ex_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ALU_CTRL_WIDTH = 3,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      StallE,
    input  logic                      FlushE,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     SignImmD,
    input  logic [REG_ADDR_WIDTH-1:0] RsD,
    input  logic [REG_ADDR_WIDTH-1:0] RtD,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    input  logic [ALU_CTRL_WIDTH-1:0] ALUControlD,
    input  logic                      ALUSrcD,
    input  logic                      RegDstD,
    input  logic                      RegWriteD,
    input  logic                      MemWriteD,
    input  logic                      MemtoRegD,
    input  logic [1:0]                ForwardAE,
    input  logic [1:0]                ForwardBE,
    input  logic [DATA_WIDTH-1:0]     ALUOutM,
    input  logic [DATA_WIDTH-1:0]     ResultW,
    output logic [DATA_WIDTH-1:0]     SrcAE,
    output logic [DATA_WIDTH-1:0]     SrcBE,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
    output logic [DATA_WIDTH-1:0]     WriteDataE,
    output logic [REG_ADDR_WIDTH-1:0] WriteRegE,
    output logic [REG_ADDR_WIDTH-1:0] RsE,
    output logic [REG_ADDR_WIDTH-1:0] RtE,
    output logic                      RegWriteE,
    output logic                      MemWriteE,
    output logic                      MemtoRegE,
    output logic                      ValidE
);

    // ------------------------------------------------------------------
    // E-stage registers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]     rd1_q,       rd1_d;
    logic [DATA_WIDTH-1:0]     rd2_q,       rd2_d;
    logic [DATA_WIDTH-1:0]     imm_q,       imm_d;
    logic [REG_ADDR_WIDTH-1:0] rs_q,        rs_d;
    logic [REG_ADDR_WIDTH-1:0] rt_q,        rt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_q,  alu_ctrl_d;
    logic                      alu_src_q,   alu_src_d;
    logic                      reg_dst_q,   reg_dst_d;
    logic                      reg_write_q, reg_write_d;
    logic                      mem_write_q, mem_write_d;
    logic                      mem_to_reg_q, mem_to_reg_d;
    logic                      valid_q,     valid_d;

    // Next-state: flush beats stall, so a killed instruction never lingers
    // even if the hazard unit also asks for a hold.
    always_comb begin
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_src_d    = alu_src_q;
        reg_dst_d    = reg_dst_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        valid_d      = valid_q;

        if (FlushE) begin
            rd1_d        = '0;
            rd2_d        = '0;
            imm_d        = '0;
            rs_d         = '0;
            rt_d         = '0;
            rd_d         = '0;
            alu_ctrl_d   = '0;
            alu_src_d    = 1'b0;
            reg_dst_d    = 1'b0;
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            valid_d      = 1'b0;
        end else if (!StallE) begin
            rd1_d        = RD1D;
            rd2_d        = RD2D;
            imm_d        = SignImmD;
            rs_d         = RsD;
            rt_d         = RtD;
            rd_d         = RdD;
            alu_ctrl_d   = ALUControlD;
            alu_src_d    = ALUSrcD;
            reg_dst_d    = RegDstD;
            reg_write_d  = RegWriteD;
            mem_write_d  = MemWriteD;
            mem_to_reg_d = MemtoRegD;
            valid_d      = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            alu_ctrl_q   <= '0;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_src_q    <= alu_src_d;
            reg_dst_q    <= reg_dst_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            valid_q      <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding muxes: combinational on the registered operands, so a
    // stalled instruction keeps picking up newly produced MEM/WB values.
    // Reserved select 11 falls back to the register value.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;

    always_comb begin
        fwd_a = rd1_q;
        case (ForwardAE)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = ALUOutM;
            default: fwd_a = rd1_q;
        endcase
    end

    always_comb begin
        fwd_b = rd2_q;
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUOutM;
            default: fwd_b = rd2_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign SrcAE       = fwd_a;
    assign SrcBE       = alu_src_q ? imm_q : fwd_b;
    assign WriteDataE  = fwd_b;
    assign WriteRegE   = reg_dst_q ? rd_q : rt_q;
    assign ALUControlE = alu_ctrl_q;
    assign RsE         = rs_q;
    assign RtE         = rt_q;
    assign RegWriteE   = reg_write_q;
    assign MemWriteE   = mem_write_q;
    assign MemtoRegE   = mem_to_reg_q;
    assign ValidE      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_id_ex_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        StallE, FlushE;
    logic [31:0] RD1D, RD2D, SignImmD;
    logic [4:0]  RsD, RtD, RdD;
    logic [2:0]  ALUControlD;
    logic        ALUSrcD, RegDstD, RegWriteD, MemWriteD, MemtoRegD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUOutM, ResultW;
    logic [31:0] SrcAE, SrcBE, WriteDataE;
    logic [2:0]  ALUControlE;
    logic [4:0]  WriteRegE, RsE, RtE;
    logic        RegWriteE, MemWriteE, MemtoRegE, ValidE;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    id_ex_stage dut (
        .CLK(CLK), .RST(RST), .StallE(StallE), .FlushE(FlushE),
        .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .RegWriteD(RegWriteD),
        .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUOutM(ALUOutM), .ResultW(ResultW),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
        .WriteDataE(WriteDataE), .WriteRegE(WriteRegE), .RsE(RsE), .RtE(RtE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .ValidE(ValidE)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: the instruction currently sitting in E.
    typedef struct packed {
        logic        valid;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [2:0]  aluc;
        logic        alusrc, regdst, regwrite, memwrite, memtoreg;
    } instr_t;

    instr_t m;

    always @(posedge CLK or negedge RST) begin
        if (!RST)        m <= '0;
        else if (FlushE) m <= '0;
        else if (!StallE)
            m <= '{valid: 1'b1, rd1: RD1D, rd2: RD2D, imm: SignImmD,
                   rs: RsD, rt: RtD, rd: RdD, aluc: ALUControlD,
                   alusrc: ALUSrcD, regdst: RegDstD, regwrite: RegWriteD,
                   memwrite: MemWriteD, memtoreg: MemtoRegD};
    end

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] regv);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return ALUOutM;
        return regv;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] fb;
        fb = pick(ForwardBE, m.rd2);
        cmp({tag, " SrcAE"}, SrcAE, pick(ForwardAE, m.rd1));
        cmp({tag, " SrcBE"}, SrcBE, m.alusrc ? m.imm : fb);
        cmp({tag, " WriteDataE"}, WriteDataE, fb);
        cmp({tag, " WriteRegE"}, {27'd0, WriteRegE}, {27'd0, m.regdst ? m.rd : m.rt});
        cmp({tag, " ALUControlE"}, {29'd0, ALUControlE}, {29'd0, m.aluc});
        cmp({tag, " RsE"}, {27'd0, RsE}, {27'd0, m.rs});
        cmp({tag, " RtE"}, {27'd0, RtE}, {27'd0, m.rt});
        cmp({tag, " ctrl"}, {28'd0, RegWriteE, MemWriteE, MemtoRegE, ValidE},
            {28'd0, m.regwrite, m.memwrite, m.memtoreg, m.valid});
    endtask

    // Single compare process against the model, away from the active edge.
    always @(negedge CLK) if (cmp_en) check_model("model");

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        StallE = 0; FlushE = 0;
        RD1D = 0; RD2D = 0; SignImmD = 0; RsD = 0; RtD = 0; RdD = 0;
        ALUControlD = 0; ALUSrcD = 0; RegDstD = 0; RegWriteD = 0;
        MemWriteD = 0; MemtoRegD = 0; ForwardAE = 0; ForwardBE = 0;
        ALUOutM = 0; ResultW = 0;
    endtask

    initial begin
        clear_inputs();
        RST = 0;
        repeat (2) step();
        // Reset state
        cmp("rst ValidE", {31'd0, ValidE}, 32'd0);
        cmp("rst RegWriteE", {31'd0, RegWriteE}, 32'd0);
        cmp("rst ALUControlE", {29'd0, ALUControlE}, 32'd0);
        RST = 1;
        cmp_en = 1;

        // Basic load
        RD1D = 5; RD2D = 7; ALUControlD = 3'b010;
        step();
        cmp("load SrcAE", SrcAE, 32'd5);
        cmp("load SrcBE", SrcBE, 32'd7);
        cmp("load ALUControlE", {29'd0, ALUControlE}, 32'd2);
        cmp("load ValidE", {31'd0, ValidE}, 32'd1);

        // Immediate mux and RegDst mux
        SignImmD = 32'hFFFF_FFFC; ALUSrcD = 1; RegDstD = 1; RdD = 9; RtD = 3;
        step();
        cmp("imm SrcBE", SrcBE, 32'hFFFF_FFFC);
        cmp("imm WriteDataE", WriteDataE, 32'd7);
        cmp("regdst1 WriteRegE", {27'd0, WriteRegE}, 32'd9);
        RegDstD = 0;
        step();
        cmp("regdst0 WriteRegE", {27'd0, WriteRegE}, 32'd3);

        // Forwarding on registered RD1E=1
        RD1D = 1; SignImmD = 32'h44;
        step();
        ALUOutM = 32'h20; ResultW = 32'h30;
        ForwardAE = 2'b10; #1 cmp("fwdA mem", SrcAE, 32'h20);
        ForwardAE = 2'b01; #1 cmp("fwdA wb", SrcAE, 32'h30);
        ForwardAE = 2'b11; #1 cmp("fwdA rsvd", SrcAE, 32'd1);
        ForwardBE = 2'b10; #1 cmp("fwdB SrcBE", SrcBE, 32'h44);
        cmp("fwdB WriteDataE", WriteDataE, 32'h20);

        // Stall: D changes ignored, forwarding still live
        StallE = 1; ForwardAE = 2'b10; ForwardBE = 2'b00;
        for (int i = 0; i < 3; i++) begin
            RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom; RtD = 5'd17;
            ALUControlD = 3'b111;
            ALUOutM = 32'h1000 + i;
            step();
            cmp("stall SrcAE", SrcAE, 32'h1000 + i);
            cmp("stall SrcBE", SrcBE, 32'h44);
            cmp("stall WriteRegE", {27'd0, WriteRegE}, 32'd3);
            cmp("stall ALUControlE", {29'd0, ALUControlE}, 32'd2);
        end

        // Flush wins over stall
        StallE = 0; RegWriteD = 1; MemWriteD = 1; ALUControlD = 3'b110;
        step();
        cmp("pre-flush ctrl", {30'd0, RegWriteE, MemWriteE}, 32'd3);
        FlushE = 1; StallE = 1;
        step();
        cmp("flush ctrl", {29'd0, RegWriteE, MemWriteE, ValidE}, 32'd0);
        cmp("flush ALUControlE", {29'd0, ALUControlE}, 32'd0);

        // Async reset mid-cycle
        FlushE = 0; StallE = 0; ForwardAE = 0; ForwardBE = 0;
        step();
        cmp("prereset ValidE", {31'd0, ValidE}, 32'd1);
        #1 RST = 0;
        #1 cmp("async rst ctrl", {29'd0, RegWriteE, ValidE, MemWriteE}, 32'd0);
        cmp("async rst ALUControlE", {29'd0, ALUControlE}, 32'd0);
        cmp("async rst SrcAE", SrcAE, 32'd0);
        #1 RST = 1;
        ALUControlD = 3'b101;
        step();
        cmp("post-reset ValidE", {31'd0, ValidE}, 32'd1);
        cmp("post-reset ALUControlE", {29'd0, ALUControlE}, 32'd5);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            StallE = ($urandom_range(0, 4) == 0);
            FlushE = ($urandom_range(0, 9) == 0);
            RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
            RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom);
            ALUControlD = 3'($urandom);
            {ALUSrcD, RegDstD, RegWriteD, MemWriteD, MemtoRegD} = 5'($urandom);
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            ALUOutM = $urandom; ResultW = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                #1 RST = 0;
                #1 check_model("rand rst");
                RST = 1;
            end
            step();
        end

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
